// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// one partial-product step per clock, load/busy/ready/valid handshake.
// Optional build macro SEQ_MULT_SIGNED_EN adds two's-complement operands
// (selected per operation by signed_mode).
module seq_mult_param #(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               busy,
   output logic               ready,
   output logic               valid,
   output logic [2*WIDTH-1:0] op
);

   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [PW-1:0]      op_q, op_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic               valid_q, valid_d;
   logic [WIDTH:0]     sum_c;
`ifdef SEQ_MULT_SIGNED_EN
   logic               neg_q, neg_d;
`else
   logic               unused_signed_mode;
   assign unused_signed_mode = signed_mode;
`endif

   // State, datapath and registered handshake outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         op_q     <= '0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
`ifdef SEQ_MULT_SIGNED_EN
         neg_q    <= neg_d;
`endif
      end
   end

   // Next-state: operand capture on accepted load, one add-shift step per RUN cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      op_d     = op_q;
      sum_c    = '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_d    = neg_q;
`endif

      if (state_q == S_RUN) begin
         // carry of the WIDTH+1-bit add becomes the new top bit after the shift
         sum_c    = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
         acc_d    = {sum_c, acc_q[WIDTH-1:1]};
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SEQ_MULT_SIGNED_EN
            op_d = neg_q ? (PW'(0) - acc_d) : acc_d;
`else
            op_d = acc_d;
`endif
            state_d = S_DONE;
         end
      end else if (load) begin
         // IDLE or DONE: accept a new operation (back-to-back from DONE)
         mcand_d  = a;
         mplier_d = b;
`ifdef SEQ_MULT_SIGNED_EN
         if (signed_mode && a[WIDTH-1]) mcand_d  = WIDTH'(0) - a;
         if (signed_mode && b[WIDTH-1]) mplier_d = WIDTH'(0) - b;
         neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
         acc_d   = '0;
         cnt_d   = '0;
         state_d = S_RUN;
      end else begin
         state_d = S_IDLE;
      end
   end

   // Handshake outputs follow the next state so they are registered
   always_comb begin
      busy_d  = (state_d == S_RUN);
      ready_d = (state_d != S_RUN);
      valid_d = (state_d == S_DONE);
   end

   assign busy  = busy_q;
   assign ready = ready_q;
   assign valid = valid_q;
   assign op    = op_q;

endmodule
